// File: rtl/hm_pkg.sv
// rtl/hm_pkg.sv - shared types and constants for the GSM free-cell pool
package hm_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } hm_state_t;

    localparam int HM_AWIDTH   = 7;
    localparam int HM_NUM_PORT = 4;

    // Count must hold the full-pool value DEPTH, one bit wider than an address.
    function automatic int hm_cnt_width(input int awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/hm_free_pool_arb_if.sv
// rtl/hm_free_pool_arb_if.sv - allocation, release and status signals of the free pool
interface hm_free_pool_arb_if
    import hm_pkg::*;
#(
    parameter int NUM_PORT = HM_NUM_PORT,
    parameter int AWIDTH   = HM_AWIDTH
) ();

    logic [NUM_PORT-1:0]                 i_hmp_rd;
    logic [NUM_PORT-1:0]                 o_hmp_valid;
    logic [NUM_PORT*AWIDTH-1:0]          o_hmp_addr;
    logic [NUM_PORT-1:0]                 o_bf_free_flag;
    logic                                i_rel_valid;
    logic [AWIDTH-1:0]                   i_rel_addr;
    logic [hm_cnt_width(AWIDTH)-1:0]     o_free_cnt;
    logic                                o_init_done;
    logic                                o_err;

    modport slave (
        input  i_hmp_rd, i_rel_valid, i_rel_addr,
        output o_hmp_valid, o_hmp_addr, o_bf_free_flag, o_free_cnt, o_init_done, o_err
    );

    modport master (
        output i_hmp_rd, i_rel_valid, i_rel_addr,
        input  o_hmp_valid, o_hmp_addr, o_bf_free_flag, o_free_cnt, o_init_done, o_err
    );

endinterface

// File: rtl/hm_free_fifo.sv
// rtl/hm_free_fifo.sv - circular free-address buffer, one write and one registered read
module hm_free_fifo
    import hm_pkg::*;
#(
    parameter int AWIDTH = HM_AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wdata,
    input  logic              rd_en,
    output logic [AWIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [AWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    // No reset on the array or read register so the buffer maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wdata;
        if (rd_en) rdata <= mem[rptr];
    end

endmodule

// File: rtl/hm_free_pool_arb.sv
// rtl/hm_free_pool_arb.sv - free-cell pool manager with round-robin allocation arbiter
module hm_free_pool_arb
    import hm_pkg::*;
#(
    parameter int NUM_PORT = HM_NUM_PORT,
    parameter int AWIDTH   = HM_AWIDTH,
    parameter int LOW_WM   = 8
) (
    input  logic                clk_80M,
    input  logic                rst_n,
    input  logic                clr_80M,
    hm_free_pool_arb_if.slave   bus
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int CW    = hm_cnt_width(AWIDTH);
    localparam int PW    = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

    hm_state_t                  state_q, state_nxt;
    logic [NUM_PORT-1:0]        pending_q;
    logic [PW-1:0]              ptr_q;
    logic [CW-1:0]              cnt_q;
    logic                       gnt_v_q;
    logic [PW-1:0]              gnt_port_q;
    logic [NUM_PORT-1:0]        valid_q;
    logic [NUM_PORT-1:0]        flag_q;
    logic [NUM_PORT*AWIDTH-1:0] addr_q;
    logic                       init_done_q;
    logic                       err_q;

    logic                       push, pop, rel_drop, gnt_found;
    logic [PW-1:0]              gnt_idx;
    logic [AWIDTH-1:0]          wdata, fifo_rdata;
    logic [NUM_PORT-1:0]        gnt_oh;
    int                         idx;

    hm_free_fifo #(.AWIDTH(AWIDTH)) u_fifo (
        .clk   (clk_80M),
        .rst_n (rst_n),
        .clr   (clr_80M),
        .wr_en (push),
        .wdata (wdata),
        .rd_en (pop),
        .rdata (fifo_rdata)
    );

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (clr_80M)
            state_nxt = INIT;
        else if (state_q == INIT && cnt_q == CW'(DEPTH - 1))
            state_nxt = RUN;
    end

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        rel_drop  = 1'b0;
        wdata     = cnt_q[AWIDTH-1:0];
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int off = 0; off < NUM_PORT; off++) begin
            idx = (int'(ptr_q) + off) % NUM_PORT;
            if (!gnt_found && pending_q[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
        case (state_q)
            INIT: begin
                // While filling, the running count doubles as the next address to write.
                push     = !clr_80M;
                rel_drop = bus.i_rel_valid;
            end
            RUN: begin
                pop = gnt_found && (cnt_q != '0) && !clr_80M;
                if (bus.i_rel_valid) begin
                    if (cnt_q == CW'(DEPTH)) rel_drop = 1'b1;
                    else                     push     = !clr_80M;
                end
                wdata = bus.i_rel_addr;
            end
            default: ;
        endcase
        gnt_oh = pop ? (NUM_PORT'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_v_q     <= 1'b0;
            gnt_port_q  <= '0;
            valid_q     <= '0;
            addr_q      <= '0;
            init_done_q <= 1'b0;
        end else if (clr_80M) begin
            pending_q   <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_v_q     <= 1'b0;
            valid_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            pending_q   <= (pending_q & ~gnt_oh) | (bus.i_hmp_rd & ~pending_q);
            cnt_q       <= cnt_q + CW'(push) - CW'(pop);
            if (pop)
                ptr_q <= (gnt_idx == PW'(NUM_PORT - 1)) ? '0 : gnt_idx + 1'b1;
            gnt_v_q     <= pop;
            gnt_port_q  <= gnt_idx;
            // Grant registered last cycle; the FIFO read data is valid now.
            valid_q     <= gnt_v_q ? (NUM_PORT'(1) << gnt_port_q) : '0;
            if (gnt_v_q)
                addr_q[gnt_port_q*AWIDTH +: AWIDTH] <= fifo_rdata;
            init_done_q <= (state_nxt == RUN);
        end
    end

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= '0;
            err_q  <= 1'b0;
        end else begin
            flag_q <= {NUM_PORT{cnt_q > CW'(LOW_WM)}};
            if (rel_drop) err_q <= 1'b1;
        end
    end

    assign bus.o_hmp_valid    = valid_q;
    assign bus.o_hmp_addr     = addr_q;
    assign bus.o_bf_free_flag = flag_q;
    assign bus.o_free_cnt     = cnt_q;
    assign bus.o_init_done    = init_done_q;
    assign bus.o_err          = err_q;

endmodule

// File: tb/tb_hm_free_pool_arb.sv
// tb/tb_hm_free_pool_arb.sv - scoreboard bench for the free-cell pool arbiter
module tb_hm_free_pool_arb;

    localparam int NP = 4;
    localparam int AW = 7;

    typedef struct {
        int port;
        int addr;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clr;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    hm_free_pool_arb_if #(.NUM_PORT(NP), .AWIDTH(AW)) bus ();

    hm_free_pool_arb #(.NUM_PORT(NP), .AWIDTH(AW), .LOW_WM(8)) dut (
        .clk_80M (clk),
        .rst_n   (rst_n),
        .clr_80M (clr),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_grant(input int port, input int addr, input int lat);
        exp_t e;
        e.port = port;
        e.addr = addr;
        e.cyc  = cyc + lat;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_hmp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'(bus.o_hmp_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("valid_port", 32'(bus.o_hmp_valid), 32'(1 << e.port));
                    chk("addr", 32'(bus.o_hmp_addr[e.port*AW +: AW]), 32'(e.addr));
                    chk("latency", 32'(cyc), 32'(e.cyc));
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("missing_valid", 32'(bus.o_hmp_valid), 32'(1 << e.port));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        bus.i_hmp_rd    = '0;
        bus.i_rel_valid = 1'b0;
        bus.i_rel_addr  = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.o_hmp_valid), 32'h0);
        chk("rst_cnt", 32'(bus.o_free_cnt), 32'h0);
        chk("rst_init_done", 32'(bus.o_init_done), 32'h0);
        chk("rst_err", 32'(bus.o_err), 32'h0);
        chk("rst_flag", 32'(bus.o_bf_free_flag), 32'h0);
        rst_n = 1'b1;

        repeat (127) @(negedge clk);
        chk("init_cnt_127", 32'(bus.o_free_cnt), 32'd127);
        chk("init_not_done", 32'(bus.o_init_done), 32'h0);
        @(negedge clk);
        chk("init_done", 32'(bus.o_init_done), 32'h1);
        chk("init_cnt_128", 32'(bus.o_free_cnt), 32'd128);
        chk("init_flag", 32'(bus.o_bf_free_flag), 32'hF);
        chk("init_err", 32'(bus.o_err), 32'h0);

        bus.i_rel_valid = 1'b1;
        bus.i_rel_addr  = 7'd3;
        @(negedge clk);
        bus.i_rel_valid = 1'b0;
        chk("full_rel_err", 32'(bus.o_err), 32'h1);
        chk("full_rel_cnt", 32'(bus.o_free_cnt), 32'd128);

        bus.i_hmp_rd = 4'hF;
        for (int p = 0; p < NP; p++) expect_grant(p, p, 3 + p);
        @(negedge clk);
        bus.i_hmp_rd = '0;
        repeat (6) @(negedge clk);
        chk("rr4_cnt", 32'(bus.o_free_cnt), 32'd124);

        bus.i_hmp_rd = 4'b0100;
        expect_grant(2, 4, 3);
        @(negedge clk);
        bus.i_hmp_rd = '0;
        repeat (3) @(negedge clk);
        chk("single_cnt", 32'(bus.o_free_cnt), 32'd123);

        bus.i_hmp_rd = 4'b0010;
        expect_grant(1, 5, 3);
        @(negedge clk);
        bus.i_hmp_rd    = '0;
        bus.i_rel_valid = 1'b1;
        bus.i_rel_addr  = 7'd0;
        @(negedge clk);
        bus.i_rel_valid = 1'b0;
        chk("gnt_rel_cnt", 32'(bus.o_free_cnt), 32'd123);
        repeat (2) @(negedge clk);

        n = 123;
        for (int i = 0; i < 123; i++) begin
            bus.i_hmp_rd = 4'b0001;
            expect_grant(0, (i < 122) ? 6 + i : 0, 3);
            @(negedge clk);
            bus.i_hmp_rd = '0;
            @(negedge clk);
            chk("drain_cnt", 32'(bus.o_free_cnt), 32'(n - 1));
            chk("drain_flag", 32'(bus.o_bf_free_flag), (n > 8) ? 32'hF : 32'h0);
            n--;
        end
        repeat (2) @(negedge clk);
        chk("empty_cnt", 32'(bus.o_free_cnt), 32'd0);

        bus.i_hmp_rd = 4'b0100;
        expect_grant(2, 5, 4);
        @(negedge clk);
        bus.i_hmp_rd    = '0;
        bus.i_rel_valid = 1'b1;
        bus.i_rel_addr  = 7'd5;
        @(negedge clk);
        bus.i_rel_valid = 1'b0;
        chk("no_bypass_cnt", 32'(bus.o_free_cnt), 32'd1);
        @(negedge clk);
        chk("rel_then_gnt_cnt", 32'(bus.o_free_cnt), 32'd0);
        repeat (2) @(negedge clk);

        bus.i_hmp_rd = 4'b1010;
        @(negedge clk);
        bus.i_hmp_rd = '0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        k = cyc;
        chk("clr_init_done", 32'(bus.o_init_done), 32'h0);
        chk("clr_cnt", 32'(bus.o_free_cnt), 32'd0);
        chk("clr_err_sticky", 32'(bus.o_err), 32'h1);
        repeat (9) @(negedge clk);
        bus.i_hmp_rd = 4'b0001;
        expect_grant(0, 0, (k + 130) - cyc);
        @(negedge clk);
        bus.i_hmp_rd = '0;
        repeat ((k + 128) - cyc) @(negedge clk);
        chk("reinit_cnt", 32'(bus.o_free_cnt), 32'd128);
        chk("reinit_done", 32'(bus.o_init_done), 32'h1);
        @(negedge clk);
        chk("init_req_cnt", 32'(bus.o_free_cnt), 32'd127);
        repeat (4) @(negedge clk);
        chk("pend_cleared_cnt", 32'(bus.o_free_cnt), 32'd127);
        chk("final_err", 32'(bus.o_err), 32'h1);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
